window3x3_pad: RTL

//  Builds a 3x3 pixel window from the three vertical taps of the upstream line buffer.

---
 rtl/window3x3_pad.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/window3x3_pad.sv
// 3x3 window former with border padding.
// Takes one vertical column (top/mid/bot taps) per beat from the padded line buffer
// and emits one 3x3 window per pixel centred on the mid tap. Out-of-frame pixels are
// replaced by PAD_VALUE. One in_ready bubble per line lets the right-edge window
// (whose right column is padding) be produced without an incoming column.
module window3x3_pad #(
    parameter int DATA_WIDTH   = 8,
    parameter int LINE_WORDS   = 10,
    parameter int FRAME_HEIGHT = 8,
    parameter int PAD_VALUE    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_top,
    input  logic [DATA_WIDTH-1:0]   in_mid,
    input  logic [DATA_WIDTH-1:0]   in_bot,
    output logic [9*DATA_WIDTH-1:0] out_window,
    output logic                    out_valid,
    output logic                    out_sol,
    output logic                    out_eol,
    output logic                    out_eof
);

    localparam int CW = $clog2(LINE_WORDS);
    localparam int RW = $clog2(FRAME_HEIGHT);
    localparam logic [CW-1:0]         COL_LAST = CW'(LINE_WORDS - 1);
    localparam logic [RW-1:0]         ROW_LAST = RW'(FRAME_HEIGHT - 1);
    localparam logic [DATA_WIDTH-1:0] PAD      = DATA_WIDTH'(PAD_VALUE);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Column layout: index 2 = top (row r-1), 1 = mid (row r), 0 = bot (row r+1).
    typedef logic [2:0][DATA_WIDTH-1:0] column_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           col_reg, col_next;
    logic [RW-1:0]           row_reg, row_next;
    column_t                 l_reg, l_next;
    column_t                 c_reg, c_next;
    logic [9*DATA_WIDTH-1:0] win_reg, win_next;
    logic                    valid_reg, valid_next;
    logic                    sol_reg, sol_next;
    logic                    eol_reg, eol_next;
    logic                    eof_reg, eof_next;

    logic                    beat;
    logic [RW-1:0]           mask_row;
    column_t                 tap_in;
    logic [2:0]              tap_pad;
    column_t                 n_col;
    column_t                 pad_col;
    logic [9*DATA_WIDTH-1:0] win_run;
    logic [9*DATA_WIDTH-1:0] win_flush;

    assign in_ready = (state_reg == ST_RUN);
    assign beat     = in_valid && in_ready;

    // A frame_start beat is row 0 regardless of where the counters were.
    assign mask_row = frame_start ? '0 : row_reg;
    assign tap_in   = {in_top, in_mid, in_bot};
    assign tap_pad  = {(mask_row == '0), 1'b0, (mask_row == ROW_LAST)};
    assign pad_col  = {PAD, PAD, PAD};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tap
            // Replace the tap that falls above/below the frame with padding.
            assign n_col[gi] = tap_pad[gi] ? PAD : tap_in[gi];

            // Window row gi (0 = top) is tap index 2-gi taken from L, C and the right column.
            assign win_run[(2-gi)*3*DATA_WIDTH +: 3*DATA_WIDTH] =
                {l_reg[2-gi], c_reg[2-gi], n_col[2-gi]};
            assign win_flush[(2-gi)*3*DATA_WIDTH +: 3*DATA_WIDTH] =
                {l_reg[2-gi], c_reg[2-gi], PAD};
        end
    endgenerate

    // Next-state logic: column shifting, window capture, counters and flush sequencing.
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        l_next     = l_reg;
        c_next     = c_reg;
        win_next   = win_reg;
        valid_next = 1'b0;
        sol_next   = sol_reg;
        eol_next   = eol_reg;
        eof_next   = eof_reg;

        if (frame_start) begin
            // Restart the frame; any pending flush is abandoned.
            state_next = ST_RUN;
            col_next   = '0;
            row_next   = '0;
            if (beat) begin
                c_next   = n_col;
                l_next   = pad_col;
                col_next = CW'(1);
            end
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (beat) begin
                        if (col_reg == '0) begin
                            // First column of a line: nothing to emit yet, left edge is padding.
                            c_next   = n_col;
                            l_next   = pad_col;
                            col_next = CW'(1);
                        end else begin
                            win_next   = win_run;
                            valid_next = 1'b1;
                            sol_next   = (col_reg == CW'(1));
                            eol_next   = 1'b0;
                            eof_next   = 1'b0;
                            l_next     = c_reg;
                            c_next     = n_col;
                            if (col_reg == COL_LAST) begin
                                state_next = ST_FLUSH;
                            end else begin
                                col_next = col_reg + CW'(1);
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    // Right-edge window: no incoming column, right side is padding.
                    win_next   = win_flush;
                    valid_next = 1'b1;
                    sol_next   = 1'b0;
                    eol_next   = 1'b1;
                    eof_next   = (row_reg == ROW_LAST);
                    col_next   = '0;
                    row_next   = (row_reg == ROW_LAST) ? '0 : row_reg + RW'(1);
                    state_next = ST_RUN;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            col_reg   <= '0;
            row_reg   <= '0;
            l_reg     <= {PAD, PAD, PAD};
            c_reg     <= {PAD, PAD, PAD};
            win_reg   <= '0;
            valid_reg <= 1'b0;
            sol_reg   <= 1'b0;
            eol_reg   <= 1'b0;
            eof_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            l_reg     <= l_next;
            c_reg     <= c_next;
            win_reg   <= win_next;
            valid_reg <= valid_next;
            sol_reg   <= sol_next;
            eol_reg   <= eol_next;
            eof_reg   <= eof_next;
        end
    end

    assign out_window = win_reg;
    assign out_valid  = valid_reg;
    assign out_sol    = sol_reg;
    assign out_eol    = eol_reg;
    assign out_eof    = eof_reg;

endmodule
